bpu_update_arb: RTL

Sequences branch-resolution updates into the branch predictor. Two requesters share the predictor's single update port: the EX conditional-branch unit and the jump unit (jal/jalr). The block arbitrates between them, buffers resolved records in a small FIFO and drains one record per cycle onto the predictor update bus. It also computes the per-record prediction-correct flag and supports hold and flush requests from pipeline control.

---
 rtl/bpu_pkg.sv | 35 +++
 rtl/bpu_rec_fifo.sv | 60 ++++++
 rtl/bpu_update_arb.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/bpu_pkg.sv
// Shared types for the branch-predictor update arbiter.
// Optional build macro: BPU_ARB_STATS_EN adds a source bit to each record.
package bpu_pkg;

    localparam int BPU_PCW = 32;

    localparam logic SRC_BR  = 1'b0;
    localparam logic SRC_JMP = 1'b1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [BPU_PCW-1:0] pc;
        logic [BPU_PCW-1:0] target;
        logic               taken;
        logic               correct;
`ifdef BPU_ARB_STATS_EN
        logic               src;
`endif
    } bpu_rec_t;

    function automatic logic calc_correct(
        input logic               pred_taken,
        input logic               taken,
        input logic [BPU_PCW-1:0] pred_target,
        input logic [BPU_PCW-1:0] target
    );
        return (pred_taken == taken) && (!taken || pred_target == target);
    endfunction

endpackage

// File: rtl/bpu_rec_fifo.sv
// Synchronous record FIFO with occupancy count and synchronous clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module bpu_rec_fifo
    import bpu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = bpu_rec_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  T                           din,
    input  logic                       pop,
    output T                           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bpu_update_arb.sv
// Arbitrates branch/jump resolutions into the predictor update port.
// Optional build macro: BPU_ARB_STATS_EN adds saturating hit/miss counters.
module bpu_update_arb
    import bpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PCW   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       br_valid,
    output logic                       br_ready,
    input  logic [PCW-1:0]             br_pc,
    input  logic [PCW-1:0]             br_target,
    input  logic                       br_taken,
    input  logic                       br_pred_taken,
    input  logic [PCW-1:0]             br_pred_target,
    input  logic                       jmp_valid,
    output logic                       jmp_ready,
    input  logic [PCW-1:0]             jmp_pc,
    input  logic [PCW-1:0]             jmp_target,
    input  logic                       jmp_pred_taken,
    input  logic [PCW-1:0]             jmp_pred_target,
    input  logic                       hold_req,
    input  logic                       flush_req,
    output logic                       bpu_update,
    output logic [PCW-1:0]             bpu_pc,
    output logic [PCW-1:0]             bpu_target,
    output logic                       bpu_taken,
    output logic                       bpu_correct,
`ifdef BPU_ARB_STATS_EN
    output logic [31:0]                br_total,
    output logic [31:0]                br_miss,
    output logic [31:0]                jmp_total,
    output logic [31:0]                jmp_miss,
`endif
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    arb_state_e state, state_nx;
    logic       rr_last_jmp;
    logic       rr_pick_jmp;
    logic       br_grant;
    logic       jmp_grant;
    logic       enq_ok;
    logic       deq;
    logic       f_full;
    logic       f_empty;
    bpu_rec_t   br_rec;
    bpu_rec_t   jmp_rec;
    bpu_rec_t   enq_rec;
    bpu_rec_t   head;

    assign enq_ok      = !f_full && (state != FLUSH);
    assign br_ready    = enq_ok;
    assign jmp_ready   = enq_ok;
    assign rr_pick_jmp = !rr_last_jmp;
    assign br_grant    = br_valid && br_ready && !(jmp_valid && rr_pick_jmp);
    assign jmp_grant   = jmp_valid && jmp_ready && !(br_valid && !rr_pick_jmp);

    // Build both candidate records and pick the granted one.
    always_comb begin
        br_rec         = '0;
        br_rec.pc      = BPU_PCW'(br_pc);
        br_rec.target  = BPU_PCW'(br_target);
        br_rec.taken   = br_taken;
        br_rec.correct = calc_correct(br_pred_taken, br_taken,
                                      BPU_PCW'(br_pred_target),
                                      BPU_PCW'(br_target));
        jmp_rec         = '0;
        jmp_rec.pc      = BPU_PCW'(jmp_pc);
        jmp_rec.target  = BPU_PCW'(jmp_target);
        jmp_rec.taken   = 1'b1;
        jmp_rec.correct = calc_correct(jmp_pred_taken, 1'b1,
                                       BPU_PCW'(jmp_pred_target),
                                       BPU_PCW'(jmp_target));
`ifdef BPU_ARB_STATS_EN
        br_rec.src  = SRC_BR;
        jmp_rec.src = SRC_JMP;
`endif
        enq_rec = jmp_grant ? jmp_rec : br_rec;
    end

    bpu_rec_fifo #(
        .DEPTH (DEPTH),
        .T     (bpu_rec_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (state == FLUSH),
        .push  (br_grant || jmp_grant),
        .din   (enq_rec),
        .pop   (deq),
        .dout  (head),
        .count (q_count),
        .full  (f_full),
        .empty (f_empty)
    );

    // FSM state and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            rr_last_jmp <= 1'b1;
        end else begin
            state <= state_nx;
            if (br_grant)       rr_last_jmp <= 1'b0;
            else if (jmp_grant) rr_last_jmp <= 1'b1;
        end
    end

    // Next state and drain decision from current-cycle hold/flush.
    always_comb begin
        state_nx = state;
        deq      = 1'b0;
        unique case (state)
            RUN: begin
                if (flush_req)     state_nx = FLUSH;
                else if (hold_req) state_nx = HOLD;
                deq = !flush_req && !hold_req && !f_empty;
            end
            HOLD: begin
                if (flush_req)     state_nx = FLUSH;
                else if (!hold_req) state_nx = RUN;
            end
            FLUSH: begin
                state_nx = hold_req ? HOLD : RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    // Registered update bus; data holds when no update is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            bpu_update  <= 1'b0;
            bpu_pc      <= '0;
            bpu_target  <= '0;
            bpu_taken   <= 1'b0;
            bpu_correct <= 1'b0;
        end else begin
            bpu_update <= deq;
            if (deq) begin
                bpu_pc      <= PCW'(head.pc);
                bpu_target  <= PCW'(head.target);
                bpu_taken   <= head.taken;
                bpu_correct <= head.correct;
            end
        end
    end

`ifdef BPU_ARB_STATS_EN
    // Saturating per-source counters, bumped as records drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            br_total  <= '0;
            br_miss   <= '0;
            jmp_total <= '0;
            jmp_miss  <= '0;
        end else if (deq) begin
            if (head.src == SRC_BR) begin
                if (br_total != '1) br_total <= br_total + 1'b1;
                if (!head.correct && br_miss != '1) br_miss <= br_miss + 1'b1;
            end else begin
                if (jmp_total != '1) jmp_total <= jmp_total + 1'b1;
                if (!head.correct && jmp_miss != '1) jmp_miss <= jmp_miss + 1'b1;
            end
        end
    end
`endif

endmodule
